// File: rtl/simple_router_buf.sv
// Buffered 1-to-NUM_PORTS router: one word/cycle in, steered by addr into per-port FIFOs; 1-cycle latency; out-of-range words are dropped and counted.
// Optional SIMPLE_ROUTER_BUF_ZERO_IDLE_EN forces each dout lane to zero while its dout_valid is low.
module simple_router_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 4,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 8,
    localparam int ADDR_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_WIDTH-1:0]           din,
    input  logic                            din_valid,
    input  logic [ADDR_WIDTH-1:0]           addr,
    output logic                            din_ready,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] dout,
    output logic [NUM_PORTS-1:0]            dout_valid,
    input  logic [NUM_PORTS-1:0]            dout_ready,
    output logic [CNT_WIDTH-1:0]            drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic                 in_range;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;

    assign in_range = 32'(addr) < $unsigned(NUM_PORTS);

    // Ready looks only at the registered full flag, so a full port never accepts in the cycle it pops.
    always_comb begin
        din_ready = 1'b0;
        if (!reset) begin
            din_ready = in_range ? !full[addr] : 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]         wr_ptr;
        logic [PW-1:0]         rd_ptr;
        logic [PW:0]           cnt;
        logic                  push;
        logic                  pop;
        logic [DATA_WIDTH-1:0] head;

        assign push     = din_valid && din_ready && in_range && (addr == ADDR_WIDTH'(p));
        assign pop      = !empty[p] && dout_ready[p];
        assign full[p]  = (cnt == FULL_CNT);
        assign empty[p] = (cnt == '0);
        assign head     = mem[rd_ptr];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end else begin
                if (push) begin
                    mem[wr_ptr] <= din;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    cnt <= cnt + 1'b1;
                end else if (pop && !push) begin
                    cnt <= cnt - 1'b1;
                end
            end
        end

        assign dout_valid[p] = !empty[p];
`ifdef SIMPLE_ROUTER_BUF_ZERO_IDLE_EN
        assign dout[p*DATA_WIDTH +: DATA_WIDTH] = empty[p] ? '0 : head;
`else
        assign dout[p*DATA_WIDTH +: DATA_WIDTH] = head;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (din_valid && din_ready && !in_range && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_simple_router_buf.sv
// Bench for simple_router_buf with 3 ports (so addr 3 is out of range) and a 2-bit drop counter.
module tb_simple_router_buf;

    localparam int DW = 32;
    localparam int NP = 3;
    localparam int DP = 4;
    localparam int CW = 2;
    localparam int AW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [DW-1:0]  din;
    logic           din_valid;
    logic [AW-1:0]  addr;
    logic           din_ready;
    logic [NP*DW-1:0] dout;
    logic [NP-1:0]  dout_valid;
    logic [NP-1:0]  dout_ready;
    logic [CW-1:0]  drop_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    simple_router_buf #(
        .DATA_WIDTH(DW),
        .NUM_PORTS (NP),
        .DEPTH     (DP),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .addr      (addr),
        .din_ready (din_ready),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .drop_cnt  (drop_cnt)
    );

    typedef struct {
        logic [31:0] d;
        logic        v;
        logic [1:0]  a;
        logic [2:0]  r;
        logic        e_rdy;
        logic [2:0]  e_vld;
        int          e_lane;
        logic [31:0] e_dat;
        logic [1:0]  e_drop;
    } vec_t;

    vec_t tbl [9];

    logic [31:0] mq [NP][$];
    int          mdrop;

    function automatic logic [31:0] lane(input int p);
        return dout[p*DW +: DW];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic v, input logic [1:0] a, input logic [2:0] r);
        din        = d;
        din_valid  = v;
        addr       = a;
        dout_ready = r;
    endtask

    task automatic chk_idle_lanes();
`ifdef SIMPLE_ROUTER_BUF_ZERO_IDLE_EN
        for (int p = 0; p < NP; p++) begin
            if (!dout_valid[p]) chk($sformatf("idle_zero%0d", p), lane(p), 32'h0);
        end
`endif
    endtask

    initial begin
        logic hold;
        logic exp_rdy;
        logic in_rng;

        // Routing to each port, then drops to addr 3 saturating a 2-bit counter at 3.
        tbl[0] = '{32'hA0, 1'b1, 2'd0, 3'b111, 1'b1, 3'b000, 0, 32'h00, 2'd0};
        tbl[1] = '{32'hA1, 1'b1, 2'd1, 3'b111, 1'b1, 3'b001, 0, 32'hA0, 2'd0};
        tbl[2] = '{32'hA2, 1'b1, 2'd2, 3'b111, 1'b1, 3'b010, 1, 32'hA1, 2'd0};
        tbl[3] = '{32'hA3, 1'b1, 2'd3, 3'b111, 1'b1, 3'b100, 2, 32'hA2, 2'd0};
        tbl[4] = '{32'hB0, 1'b1, 2'd3, 3'b111, 1'b1, 3'b000, 0, 32'h00, 2'd1};
        tbl[5] = '{32'hB1, 1'b1, 2'd3, 3'b111, 1'b1, 3'b000, 0, 32'h00, 2'd2};
        tbl[6] = '{32'hB2, 1'b1, 2'd3, 3'b111, 1'b1, 3'b000, 0, 32'h00, 2'd3};
        tbl[7] = '{32'hB3, 1'b1, 2'd3, 3'b111, 1'b1, 3'b000, 0, 32'h00, 2'd3};
        tbl[8] = '{32'h00, 1'b0, 2'd0, 3'b111, 1'b1, 3'b000, 0, 32'h00, 2'd3};

        reset = 1'b1;
        drive(32'h0, 1'b0, 2'd0, 3'b000);
        #3;
        chk("rst_din_ready", din_ready, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_dout", dout[31:0] | dout[63:32] | dout[95:64], 0);
        step();
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].d, tbl[i].v, tbl[i].a, tbl[i].r);
            #1;
            chk($sformatf("tbl%0d_rdy", i), din_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_vld", i), dout_valid, tbl[i].e_vld);
            if (tbl[i].e_vld != 3'b000) chk($sformatf("tbl%0d_dat", i), lane(tbl[i].e_lane), tbl[i].e_dat);
            chk($sformatf("tbl%0d_drop", i), drop_cnt, tbl[i].e_drop);
            chk_idle_lanes();
            step();
        end

        // Port 1 stalled: four words fill it, port 2 still flows.
        for (int i = 0; i < 4; i++) begin
            drive(32'h10 + i, 1'b1, 2'd1, 3'b101);
            #1;
            chk($sformatf("fill%0d_rdy", i), din_ready, 1);
            step();
        end
        drive(32'h22, 1'b1, 2'd2, 3'b101);
        #1;
        chk("iso_rdy", din_ready, 1);
        step();
        drive(32'h14, 1'b1, 2'd1, 3'b101);
        #1;
        chk("iso_vld2", dout_valid[2], 1);
        chk("iso_dat2", lane(2), 32'h22);
        chk("full_rdy0", din_ready, 0);
        step();
        #1;
        chk("full_rdy1", din_ready, 0);
        chk("full_head", lane(1), 32'h10);
        step();
        dout_ready = 3'b111;
        #1;
        chk("pop_edge_rdy", din_ready, 0);
        chk("pop_dat0", lane(1), 32'h10);
        step();
        #1;
        chk("after_pop_rdy", din_ready, 1);
        chk("pop_dat1", lane(1), 32'h11);
        step();
        din_valid = 1'b0;
        for (int i = 2; i < 5; i++) begin
            #1;
            chk($sformatf("drain%0d_vld", i), dout_valid[1], 1);
            chk($sformatf("drain%0d_dat", i), lane(1), 32'h10 + i);
            step();
        end
        #1;
        chk("drain_empty", dout_valid[1], 0);
        step();

        // Port 0 at count 2, then a simultaneous push and pop.
        drive(32'h30, 1'b1, 2'd0, 3'b000);
        step();
        drive(32'h31, 1'b1, 2'd0, 3'b000);
        step();
        drive(32'h32, 1'b1, 2'd0, 3'b001);
        #1;
        chk("pp_rdy", din_ready, 1);
        chk("pp_dat0", lane(0), 32'h30);
        step();
        drive(32'h0, 1'b0, 2'd0, 3'b000);
        #1;
        chk("pp_dat1", lane(0), 32'h31);
        step();
        dout_ready = 3'b001;
        #1;
        chk("pp_held", lane(0), 32'h31);
        step();
        #1;
        chk("pp_dat2", lane(0), 32'h32);
        step();
        #1;
        chk("pp_empty", dout_valid[0], 0);
        step();

        // Async reset between edges with three words buffered and drop_cnt saturated.
        for (int i = 0; i < 3; i++) begin
            drive(32'h40 + i, 1'b1, AW'(i), 3'b000);
            step();
        end
        din_valid = 1'b0;
        #1;
        chk("pre_rst_vld", dout_valid, 3'b111);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_vld", dout_valid, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        chk("mid_rst_rdy", din_ready, 0);
        chk("mid_rst_dout", dout[31:0] | dout[63:32] | dout[95:64], 0);
        step();
        #2;
        reset = 1'b0;
        drive(32'h55, 1'b1, 2'd0, 3'b111);
        #1;
        chk("post_rst_rdy", din_ready, 1);
        chk("post_rst_vld", dout_valid, 0);
        step();
        din_valid = 1'b0;
        #1;
        chk("post_rst_vld1", dout_valid, 3'b001);
        chk("post_rst_dat", lane(0), 32'h55);
        step();
        #1;
        chk("post_rst_once", dout_valid, 0);
        chk_idle_lanes();
        step();

        // Randomised traffic against a queue model.
        mdrop = 0;
        hold  = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (!hold) begin
                din       = $urandom;
                din_valid = ($urandom_range(0, 9) < 7);
                addr      = AW'($urandom_range(0, 3));
            end
            for (int p = 0; p < NP; p++) begin
                dout_ready[p] = ($urandom_range(0, 9) < (((c / 50) % 2 == 1) ? 8 : 2));
            end
            #1;
            in_rng  = (int'(addr) < NP);
            exp_rdy = 1'b1;
            if (in_rng) exp_rdy = (mq[addr].size() < DP);
            chk("rnd_rdy", din_ready, exp_rdy);
            for (int p = 0; p < NP; p++) begin
                chk("rnd_vld", dout_valid[p], mq[p].size() > 0);
                if (mq[p].size() > 0) chk("rnd_dat", lane(p), mq[p][0]);
            end
            chk("rnd_drop", drop_cnt, mdrop);
            for (int p = 0; p < NP; p++) begin
                if (mq[p].size() > 0 && dout_ready[p]) void'(mq[p].pop_front());
            end
            if (din_valid && exp_rdy) begin
                if (in_rng) mq[addr].push_back(din);
                else if (mdrop < 3) mdrop++;
            end
            hold = din_valid && !exp_rdy;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
